// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-side memory bank: funct3 encodings and FSM states.
package riscv_mem_pkg;

  // funct3 encodings for loads/stores; the low two bits give the access size
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size taken from funct3[1:0]
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {ST_INIT, ST_RUN} mem_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Lane steering for the memory bank. Store side: byte enables, lane replication
// and misalign/illegal-funct3 flags for the incoming request. Load side: lane
// selection and sign/zero extension of the word captured on the accept edge.
module lsu_lane_align
  import riscv_mem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] ld_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic        misalign,
  output logic        illegal,
  output logic [31:0] load_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Request-side decode: legality, alignment, enables and replicated store data
  always_comb begin
    byte_en   = 4'b0000;
    wdata_rep = wdata;
    misalign  = 1'b0;
    if (we) begin
      illegal = funct3[2] | (funct3 == 3'b011);
    end else begin
      illegal = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
    end
    case (funct3[1:0])
      SZ_B: begin
        byte_en   = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_H: begin
        misalign  = offset[0];
        byte_en   = offset[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      SZ_W: begin
        misalign  = (offset != 2'b00);
        byte_en   = 4'b1111;
        wdata_rep = wdata;
      end
      default: begin
        byte_en   = 4'b0000;
        wdata_rep = wdata;
      end
    endcase
  end

  // Response-side extraction: pick the addressed lane and extend it to 32 bits
  always_comb begin
    case (ld_offset)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = ld_offset[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_funct3)
      F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   load_data = {24'h000000, ld_byte};
      F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   load_data = {16'h0000, ld_half};
      F3_W:    load_data = ld_word;
      default: load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/ram_lsu_bank.sv
// Data memory bank with load/store front end. After reset an INIT state
// optionally sweeps zeros through the array, then the bank serves one access
// per cycle with a registered one-cycle response (RVALID/RDATA/ERR).
module ram_lsu_bank
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = 12,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              REQ,
  input  logic              WE,
  input  logic [2:0]        FUNCT3,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [31:0]       WDATA,
  output logic              READY,
  output logic              RVALID,
  output logic [31:0]       RDATA,
  output logic              ERR,
  output logic              INIT_DONE
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_LIMIT = ADDR_W'(DEPTH);
  localparam logic [IDX_W-1:0]  CNT_LAST    = IDX_W'(DEPTH - 1);

  mem_state_t         state;
  logic [IDX_W-1:0]   cnt;
  logic [31:0]        mem [DEPTH];
  logic [31:0]        rd_raw;
  logic [2:0]         ld_f3_q;
  logic [1:0]         ld_off_q;
  logic               resp_load_ok;
  logic               rvalid_q;
  logic               err_q;

  logic [ADDR_W-3:0]  word_idx;
  logic [IDX_W-1:0]   mem_idx;
  logic               out_of_range;
  logic               misalign;
  logic               illegal;
  logic               acc_err;
  logic               accept;
  logic               do_store;
  logic               do_load;
  logic               clear_en;
  logic [3:0]         byte_en;
  logic [31:0]        wdata_rep;
  logic [31:0]        load_data;

  assign word_idx     = ADDR[ADDR_W-1:2];
  assign mem_idx      = word_idx[IDX_W-1:0];
  assign out_of_range = ({2'b00, word_idx} >= DEPTH_LIMIT);
  assign acc_err      = out_of_range | misalign | illegal;
  assign accept       = REQ & READY;
  assign do_store     = accept & WE & ~acc_err;
  assign do_load      = accept & ~WE & ~acc_err;
  assign clear_en     = (state == ST_INIT) && (CLEAR_ON_RESET != 0);

  assign READY     = (state == ST_RUN);
  assign INIT_DONE = (state == ST_RUN);
  assign RVALID    = rvalid_q;
  assign ERR       = err_q;
  assign RDATA     = resp_load_ok ? load_data : 32'h0000_0000;

  lsu_lane_align u_align (
    .we        (WE),
    .funct3    (FUNCT3),
    .offset    (ADDR[1:0]),
    .wdata     (WDATA),
    .ld_funct3 (ld_f3_q),
    .ld_offset (ld_off_q),
    .ld_word   (rd_raw),
    .byte_en   (byte_en),
    .wdata_rep (wdata_rep),
    .misalign  (misalign),
    .illegal   (illegal),
    .load_data (load_data)
  );

  // Init/run FSM: INIT walks the clear counter across the array (or lasts one cycle)
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (CLEAR_ON_RESET == 0) begin
            state <= ST_RUN;
          end else if (cnt == CNT_LAST) begin
            state <= ST_RUN;
          end else begin
            cnt <= cnt + IDX_W'(1);
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Storage array and raw read register; deliberately not reset, the sweep clears it
  always_ff @(posedge CLK) begin
    if (clear_en) begin
      mem[cnt] <= 32'h0000_0000;
    end else if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[mem_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
        end
      end
    end
    if (do_load) begin
      rd_raw <= mem[mem_idx];
    end
  end

  // Response registers: one RVALID per accept, load context held until the next accept
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rvalid_q     <= 1'b0;
      err_q        <= 1'b0;
      resp_load_ok <= 1'b0;
      ld_f3_q      <= F3_B;
      ld_off_q     <= 2'b00;
    end else begin
      rvalid_q <= accept;
      err_q    <= accept & acc_err;
      if (accept) begin
        resp_load_ok <= do_load;
      end
      if (do_load) begin
        ld_f3_q  <= FUNCT3;
        ld_off_q <= ADDR[1:0];
      end
    end
  end

endmodule
